// File: rtl/tlc_pkg.sv
// Shared encodings for the intersection controller: state codes, lamp triple, timer width.
// Pure declarations; no logic, no latency.
package tlc_pkg;

   localparam int TIMER_W = 8;
   typedef logic [TIMER_W-1:0] timer_t;

   typedef enum logic [2:0] {
      ST_A_GREEN  = 3'd0,
      ST_A_YELLOW = 3'd1,
      ST_ALLRED_A = 3'd2,
      ST_B_GREEN  = 3'd3,
      ST_B_YELLOW = 3'd4,
      ST_ALLRED_B = 3'd5,
      ST_WALK     = 3'd6
   } state_e;

   typedef struct packed {
      logic red;
      logic yellow;
      logic green;
   } lamp_t;

   localparam lamp_t LAMP_RED    = lamp_t'(3'b100);
   localparam lamp_t LAMP_YELLOW = lamp_t'(3'b010);
   localparam lamp_t LAMP_GREEN  = lamp_t'(3'b001);

   function automatic timer_t sat_inc(input timer_t t);
      return (t == '1) ? t : t + timer_t'(1);
   endfunction

endpackage

// File: rtl/tlc_intersection_if.sv
// Request inputs and lamp/debug outputs of the intersection controller.
// master = requester/observer side, slave = controller side.
interface tlc_intersection_if;
   logic       req_b;
   logic       ped_req;
   logic       a_red;
   logic       a_yellow;
   logic       a_green;
   logic       b_red;
   logic       b_yellow;
   logic       b_green;
   logic       walk;
   logic [2:0] phase;

   modport master (
      output req_b, ped_req,
      input  a_red, a_yellow, a_green, b_red, b_yellow, b_green, walk, phase
   );

   modport slave (
      input  req_b, ped_req,
      output a_red, a_yellow, a_green, b_red, b_yellow, b_green, walk, phase
   );
endinterface

// File: rtl/tlc_phase_timer.sv
// Cycle-in-phase counter: sync clear to 0, +1 when enabled, saturates at all-ones.
// count is the registered value; count_nx is what it becomes on the next edge.
module tlc_phase_timer
   import tlc_pkg::*;
(
   input  logic   clk,
   input  logic   clr,
   input  logic   en,
   output timer_t count,
   output timer_t count_nx
);

   timer_t count_q;
   timer_t count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         count_d = sat_inc(count_q);
      end
   end

   always_ff @(posedge clk) begin
      count_q <= count_d;
   end

   assign count    = count_q;
   assign count_nx = count_d;

endmodule

// File: rtl/tlc_intersection.sv
// Two-road + pedestrian intersection scheduler; Moore lamps change on the state edge.
// Requests are latched and served B, then WALK, then A; inputs are never back-pressured.
module tlc_intersection
   import tlc_pkg::*;
#(
   parameter int GREEN_MIN = 4,
   parameter int GREEN_MAX = 8,
   parameter int YELLOW_T  = 2,
   parameter int ALLRED_T  = 1,
   parameter int WALK_T    = 3
)(
   input  logic            clk,
   input  logic            clear_n,
   tlc_intersection_if.slave bus
);

   localparam timer_t GMIN_LAST = timer_t'(GREEN_MIN - 1);
   localparam timer_t GMAX_LAST = timer_t'(GREEN_MAX - 1);
   localparam timer_t YEL_LAST  = timer_t'(YELLOW_T - 1);
   localparam timer_t ARED_LAST = timer_t'(ALLRED_T - 1);
   localparam timer_t WALK_LAST = timer_t'(WALK_T + ALLRED_T - 1);
   localparam timer_t WALK_LEN  = timer_t'(WALK_T);

   state_e state_q, state_d;
   logic   b_pend_q, b_pend_d;
   logic   p_pend_q, p_pend_d;
   lamp_t  a_lamp_q, a_lamp_d;
   lamp_t  b_lamp_q, b_lamp_d;
   logic   walk_q, walk_d;
   timer_t timer_q;
   timer_t timer_nx;
   logic   timer_clr;

   tlc_phase_timer u_timer (
      .clk      (clk),
      .clr      (timer_clr),
      .en       (1'b1),
      .count    (timer_q),
      .count_nx (timer_nx)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_A_GREEN:  if (timer_q >= GMIN_LAST && (b_pend_q || p_pend_q)) state_d = ST_A_YELLOW;
         ST_A_YELLOW: if (timer_q == YEL_LAST) state_d = ST_ALLRED_A;
         ST_ALLRED_A: if (timer_q == ARED_LAST)
                         state_d = b_pend_q ? ST_B_GREEN : (p_pend_q ? ST_WALK : ST_A_GREEN);
         ST_B_GREEN:  if ((timer_q >= GMIN_LAST && !bus.req_b) || timer_q == GMAX_LAST)
                         state_d = ST_B_YELLOW;
         ST_B_YELLOW: if (timer_q == YEL_LAST) state_d = ST_ALLRED_B;
         ST_ALLRED_B: if (timer_q == ARED_LAST) state_d = p_pend_q ? ST_WALK : ST_A_GREEN;
         ST_WALK:     if (timer_q == WALK_LAST) state_d = ST_A_GREEN;
         default:     state_d = ST_ALLRED_B;
      endcase
   end

   assign timer_clr = !clear_n || (state_d != state_q);

   // Entering the served phase clears its latch even if the request is sampled on that same edge.
   always_comb begin
      b_pend_d = b_pend_q | (bus.req_b && state_q != ST_B_GREEN);
      if (state_d == ST_B_GREEN && state_q != ST_B_GREEN) b_pend_d = 1'b0;
      p_pend_d = p_pend_q | (bus.ped_req && state_q != ST_WALK);
      if (state_d == ST_WALK && state_q != ST_WALK) p_pend_d = 1'b0;

      a_lamp_d = LAMP_RED;
      b_lamp_d = LAMP_RED;
      case (state_d)
         ST_A_GREEN:  a_lamp_d = LAMP_GREEN;
         ST_A_YELLOW: a_lamp_d = LAMP_YELLOW;
         ST_B_GREEN:  b_lamp_d = LAMP_GREEN;
         ST_B_YELLOW: b_lamp_d = LAMP_YELLOW;
         default:     ;
      endcase
      walk_d = (state_d == ST_WALK) && (timer_nx < WALK_LEN);
   end

   always_ff @(posedge clk) begin
      if (!clear_n) begin
         state_q  <= ST_ALLRED_B;
         b_pend_q <= 1'b0;
         p_pend_q <= 1'b0;
         a_lamp_q <= LAMP_RED;
         b_lamp_q <= LAMP_RED;
         walk_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         b_pend_q <= b_pend_d;
         p_pend_q <= p_pend_d;
         a_lamp_q <= a_lamp_d;
         b_lamp_q <= b_lamp_d;
         walk_q   <= walk_d;
      end
   end

   assign bus.a_red    = a_lamp_q.red;
   assign bus.a_yellow = a_lamp_q.yellow;
   assign bus.a_green  = a_lamp_q.green;
   assign bus.b_red    = b_lamp_q.red;
   assign bus.b_yellow = b_lamp_q.yellow;
   assign bus.b_green  = b_lamp_q.green;
   assign bus.walk     = walk_q;
   assign bus.phase    = state_q;

endmodule

// File: tb/tb_tlc_intersection.sv
// Directed phase-by-phase bench for tlc_intersection at default parameters.
module tb_tlc_intersection;
   import tlc_pkg::*;

   logic clk = 1'b0;
   logic clear_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   tlc_intersection_if bus();

   tlc_intersection #(
      .GREEN_MIN (4),
      .GREEN_MAX (8),
      .YELLOW_T  (2),
      .ALLRED_T  (1),
      .WALK_T    (3)
   ) dut (
      .clk     (clk),
      .clear_n (clear_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // {phase, a r/y/g, b r/y/g, walk}, hand-written per phase
   function automatic logic [9:0] expect_vec(input logic [2:0] ph, input logic w);
      logic [2:0] a;
      logic [2:0] b;
      case (ph)
         3'd0:    begin a = 3'b001; b = 3'b100; end
         3'd1:    begin a = 3'b010; b = 3'b100; end
         3'd3:    begin a = 3'b100; b = 3'b001; end
         3'd4:    begin a = 3'b100; b = 3'b010; end
         default: begin a = 3'b100; b = 3'b100; end
      endcase
      return {ph, a, b, w};
   endfunction

   function automatic logic [9:0] observed();
      return {bus.phase, bus.a_red, bus.a_yellow, bus.a_green,
              bus.b_red, bus.b_yellow, bus.b_green, bus.walk};
   endfunction

   task automatic step(input string tag, input logic [2:0] ph, input logic w);
      check(tag, {22'd0, observed()}, {22'd0, expect_vec(ph, w)});
      @(negedge clk);
   endtask

   task automatic run(input string tag, input logic [2:0] ph, input int n);
      for (int i = 0; i < n; i++) begin
         step(tag, ph, (ph == 3'd6) && (i < 3));
      end
   endtask

   initial begin
      bus.req_b   = 1'b0;
      bus.ped_req = 1'b0;

      // reset held for two edges, then released
      @(negedge clk);
      @(negedge clk);
      step("reset", 3'd5, 1'b0);
      clear_n = 1'b1;
      step("reset_release", 3'd5, 1'b0);

      // short B demand pulsed at A-green cycle 1
      step("shortB_a0", 3'd0, 1'b0);
      bus.req_b = 1'b1;
      step("shortB_a1", 3'd0, 1'b0);
      bus.req_b = 1'b0;
      run("shortB_a", 3'd0, 2);
      run("shortB_ay", 3'd1, 2);
      run("shortB_ar", 3'd2, 1);
      run("shortB_bg", 3'd3, 4);
      run("shortB_by", 3'd4, 2);
      run("shortB_br", 3'd5, 1);

      // idle: A green rests indefinitely
      run("idle", 3'd0, 50);

      // B held: B green capped at GREEN_MAX, then b_pend re-latches
      bus.req_b = 1'b1;
      run("held_a", 3'd0, 2);
      run("held_ay", 3'd1, 2);
      run("held_ar", 3'd2, 1);
      run("held_bg", 3'd3, 8);
      run("held_by", 3'd4, 2);
      run("held_br", 3'd5, 1);
      bus.req_b = 1'b0;
      run("held_a2", 3'd0, 4);
      run("held_ay2", 3'd1, 2);
      run("held_ar2", 3'd2, 1);
      run("held_bg2", 3'd3, 4);
      run("held_by2", 3'd4, 2);
      run("held_br2", 3'd5, 1);

      // simultaneous vehicle and pedestrian requests: B, then WALK, then A
      bus.req_b   = 1'b1;
      bus.ped_req = 1'b1;
      step("sim_a0", 3'd0, 1'b0);
      bus.req_b   = 1'b0;
      bus.ped_req = 1'b0;
      run("sim_a", 3'd0, 3);
      run("sim_ay", 3'd1, 2);
      run("sim_ar", 3'd2, 1);
      run("sim_bg", 3'd3, 4);
      run("sim_by", 3'd4, 2);
      run("sim_br", 3'd5, 1);
      run("sim_walk", 3'd6, 4);
      check("sim_b_pend", {31'd0, dut.b_pend_q}, 32'd0);
      check("sim_p_pend", {31'd0, dut.p_pend_q}, 32'd0);
      run("sim_a_rest", 3'd0, 10);

      // reset during B_GREEN cycle 2 abandons the phase and clears both latches
      bus.req_b   = 1'b1;
      bus.ped_req = 1'b1;
      step("rst_a0", 3'd0, 1'b0);
      bus.req_b   = 1'b0;
      bus.ped_req = 1'b0;
      step("rst_a1", 3'd0, 1'b0);
      run("rst_ay", 3'd1, 2);
      run("rst_ar", 3'd2, 1);
      run("rst_bg", 3'd3, 2);
      clear_n = 1'b0;
      step("rst_bg2", 3'd3, 1'b0);
      check("rst_phase", {29'd0, bus.phase}, 32'd5);
      check("rst_lamps", {22'd0, observed()}, {22'd0, expect_vec(3'd5, 1'b0)});
      check("rst_b_pend", {31'd0, dut.b_pend_q}, 32'd0);
      check("rst_p_pend", {31'd0, dut.p_pend_q}, 32'd0);
      clear_n = 1'b1;
      step("rst_release", 3'd5, 1'b0);
      run("rst_a_rest", 3'd0, 10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/tlc_intersection.md
# tlc_intersection

Two-road intersection controller that sequences the red/yellow/green lamps of a main road (A) and a side road (B), plus a pedestrian walk phase. Road A rests in green until there is demand. Vehicle-sensor and pedestrian requests are latched and served in a fixed order, with yellow and all-red clearance intervals between conflicting phases. It is the scheduling layer above the single-road light sequencing and shares the intersection between three requesters: road A, road B and pedestrians.

## Interface
- GREEN_MIN, 4: minimum green length in cycles for either road, 1..255
- GREEN_MAX, 8: maximum B green length in cycles, GREEN_MIN..255
- YELLOW_T, 2: yellow length in cycles, 1..255
- ALLRED_T, 1: all-red clearance in cycles, 1..255
- WALK_T, 3: walk-lamp length in cycles, 1..255
- clk  input  1  single clock; all state changes on rising edge
- clear_n  input  1  reset, synchronous, active-low
- req_b  input  1  road-B vehicle sensor, level, sampled every cycle
- ped_req  input  1  pedestrian button, sampled every cycle
- a_red, a_yellow, a_green  output  1 each  road-A lamps, exactly one high
- b_red, b_yellow, b_green  output  1 each  road-B lamps, exactly one high
- walk  output  1  pedestrian walk lamp
- phase  output  3  current state encoding, for debug and monitoring

## Operation
- States: A_GREEN, A_YELLOW, ALLRED_A, B_GREEN, B_YELLOW, ALLRED_B, WALK.
- Lamps decode from state (Moore):
  - A_GREEN: a_green, b_red.
  - A_YELLOW: a_yellow, b_red.
  - B_GREEN: b_green, a_red.
  - B_YELLOW: b_yellow, a_red.
  - ALLRED_*: a_red, b_red.
  - WALK: a_red, b_red; walk=1 for the first WALK_T cycles, then 0.
- timer: 8-bit cycle-in-state counter. Clears to 0 on every state transition, otherwise +1, saturating at 255. A state of length N exits when timer==N-1.
- b_pend: set when req_b=1 in any state except B_GREEN. Cleared on the edge entering B_GREEN.
- p_pend: set when ped_req=1 in any state except WALK. Cleared on the edge entering WALK.
- Entry-edge collisions: if a request is sampled on the same edge that clears its latch, the clear wins; that request is served by the phase being entered.
- Transitions:
  - A_GREEN → A_YELLOW when timer≥GREEN_MIN-1 and (b_pend or p_pend). Otherwise A_GREEN holds indefinitely.
  - A_YELLOW → ALLRED_A at timer==YELLOW_T-1.
  - ALLRED_A at timer==ALLRED_T-1 → B_GREEN if b_pend, else WALK if p_pend, else A_GREEN.
  - B_GREEN → B_YELLOW when (timer≥GREEN_MIN-1 and req_b=0) or timer==GREEN_MAX-1.
  - B_YELLOW → ALLRED_B at timer==YELLOW_T-1.
  - ALLRED_B at timer==ALLRED_T-1 → WALK if p_pend, else A_GREEN.
  - WALK → A_GREEN at timer==WALK_T+ALLRED_T-1. The last ALLRED_T cycles are pedestrian clearance.
- Service order when both latches are set: B first, then WALK, then A. A always receives green between two consecutive B or WALK phases.
- Any state encoding not listed forces ALLRED_B with timer 0 on the next edge.

## Timing
- clear_n=0 sampled at an edge sets state=ALLRED_B, timer=0, b_pend=0, p_pend=0.
  - Outputs during reset: a_red=b_red=1, all other lamps 0, walk=0.
  - This applies in any state, including mid-yellow or mid-walk; the interrupted phase is abandoned.
- After clear_n rises, A_GREEN follows after ALLRED_T clock edges.
- Lamps change on the same edge as the state; no extra output register.
- A request sampled at edge k is visible in the pending latch after edge k. It can trigger an exit at edge k+1 at the earliest.
- Phase lengths are exact:
  - yellow = YELLOW_T cycles
  - all-red = ALLRED_T cycles
  - WALK = WALK_T+ALLRED_T cycles
  - B green = GREEN_MIN..GREEN_MAX cycles

## Structure
- Package tlc_pkg holds:
  - the 3-bit state encoding constants (shared with the single-road sequencer's lamp constants)
  - a lamp-triple type
  - the 8-bit timer width constant
- Sub-module tlc_phase_timer: 8-bit counter with synchronous clear, enable and saturation. It is the natural split; everything else stays in one FSM module.

## Test plan
All scenarios use default parameters.
- Reset: clear_n low 2 cycles → a_red=b_red=1, walk=0. One edge after release → a_green=1, b_red=1.
- Idle: no requests for 50 cycles → a_green stays high the whole time; phase is constant.
- Short B demand: req_b pulsed 1 cycle at A-green cycle 1 → 4 A-green, 2 A-yellow, 1 all-red, 4 B-green, 2 B-yellow, 1 all-red, then A-green.
- B held: req_b=1 continuously → B green lasts exactly 8 cycles. After returning, A green lasts 4 cycles before the next yellow, because b_pend re-latches.
- Simultaneous ped_req and req_b in one A-green cycle → B green, then WALK with walk=1 for 3 cycles and 0 for 1 cycle, then A green. Neither latch remains set.
- clear_n low during B_GREEN cycle 2 → next edge a_red=b_red=1 and both latches cleared. A green follows 1 edge after release.
